// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared types, constants and round helpers for AES-128 enc  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    localparam logic [3:0] c_NUM_ROUNDS = 4'd10;
    localparam logic [7:0] c_RCON_INIT  = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_sbox : combinational forward AES S-box, one byte                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_pkg::*;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x4, w_x8, w_x16;
    logic [7:0] w_norm, w_n2, w_n4, w_n8, w_n14;
    logic [7:0] w_inv;

    // Inversion through the GF(2^4) subfield: the norm x^17 lies in GF(16),
    // where its inverse is n^14, so x^-1 = x^16 * n^14 (and 0 maps to 0).
    assign w_x2   = gf_mul(i_byte, i_byte);
    assign w_x4   = gf_mul(w_x2, w_x2);
    assign w_x8   = gf_mul(w_x4, w_x4);
    assign w_x16  = gf_mul(w_x8, w_x8);
    assign w_norm = gf_mul(w_x16, i_byte);
    assign w_n2   = gf_mul(w_norm, w_norm);
    assign w_n4   = gf_mul(w_n2, w_n2);
    assign w_n8   = gf_mul(w_n4, w_n4);
    assign w_n14  = gf_mul(gf_mul(w_n8, w_n4), w_n2);
    assign w_inv  = gf_mul(w_x16, w_n14);

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/aes128_enc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes128_enc_core : iterative AES-128 encryptor, one round per clock   |
// | Optional last_key export under AES_ENC_LAST_KEY_EN.  Rev 1.0         |
// +----------------------------------------------------------------------+
module aes128_enc_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] key,
    input  logic [0:127] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext,
    output logic         busy
`ifdef AES_ENC_LAST_KEY_EN
    ,
    output logic [0:127] last_key
`endif
);
    import aes_pkg::*;

    aes_state_e   state_q, state_d;
    logic [0:127] blk_q, blk_d;
    logic [0:127] rk_q, rk_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic [0:127] w_sb, w_sr, w_mc, w_next_rk;
    logic [0:31]  w_sw, w_temp, w_k0, w_k1, w_k2, w_k3;
    logic         w_last_round;

    generate
        for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
            aes_sbox u_sbox (
                .i_byte (blk_q[8*i +: 8]),
                .o_byte (w_sb[8*i +: 8])
            );
        end
        // SubWord(RotWord(w3)): w3 is bytes 12..15, rotated by one byte.
        for (genvar j = 0; j < 4; j++) begin : g_sub_word
            aes_sbox u_sbox (
                .i_byte (rk_q[8*(12+((j+1)%4)) +: 8]),
                .o_byte (w_sw[8*j +: 8])
            );
        end
    endgenerate

    assign w_temp    = w_sw ^ {rcon_q, 24'h000000};
    assign w_k0      = rk_q[0:31]   ^ w_temp;
    assign w_k1      = rk_q[32:63]  ^ w_k0;
    assign w_k2      = rk_q[64:95]  ^ w_k1;
    assign w_k3      = rk_q[96:127] ^ w_k2;
    assign w_next_rk = {w_k0, w_k1, w_k2, w_k3};

    assign w_last_round = (round_q == c_NUM_ROUNDS);
    assign w_sr         = shift_rows(w_sb);
    assign w_mc         = w_last_round ? w_sr : mix_columns(w_sr);

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    blk_d   = plaintext ^ key;
                    rk_d    = key;
                    rcon_d  = c_RCON_INIT;
                    round_d = 4'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                blk_d  = w_mc ^ w_next_rk;
                rk_d   = w_next_rk;
                rcon_d = xtime(rcon_q);
                if (w_last_round) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake/status outputs are registered from the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            blk_q       <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h00;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef AES_ENC_LAST_KEY_EN
    logic [0:127] last_key_q, last_key_d;

    always_comb begin
        last_key_d = last_key_q;
        if (state_q == ST_ROUND && w_last_round) last_key_d = w_next_rk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q <= '0;
        end else begin
            last_key_q <= last_key_d;
        end
    end

    assign last_key = last_key_q;
`endif

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_enc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes128_enc_core : directed FIPS-197 vectors, handshake and reset  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_aes128_enc_core;

    localparam logic [0:127] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] c_C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [0:127] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] c_B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [0:127] key = '0;
    logic [0:127] plaintext = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [0:127] ciphertext;
`ifdef AES_ENC_LAST_KEY_EN
    logic [0:127] last_key;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes128_enc_core u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
`ifdef AES_ENC_LAST_KEY_EN
        ,
        .last_key   (last_key)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one block for exactly the accept edge, then scrambles the inputs.
    task automatic start(input logic [0:127] k, input logic [0:127] p);
        key       = k;
        plaintext = p;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        key       = ~k;
        plaintext = ~p;
        check_eq("busy_after_accept", 128'(busy), 128'd1);
        check_eq("in_ready_after_accept", 128'(in_ready), 128'd0);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("out_valid_after_handshake", 128'(out_valid), 128'd0);
        check_eq("in_ready_after_handshake", 128'(in_ready), 128'd1);
        check_eq("busy_after_handshake", 128'(busy), 128'd0);
    endtask

    task automatic run_vec(input string tag, input logic [0:127] k, input logic [0:127] p,
                           input logic [0:127] ct, input logic [0:127] lk);
        int n;
        start(k, p);
        wait_out(n);
        // out_valid must rise right after E10, i.e. ten edges past the accept edge.
        check_eq({tag, "_latency"}, 128'(n), 128'd10);
        check_eq({tag, "_ct"}, ciphertext, ct);
`ifdef AES_ENC_LAST_KEY_EN
        check_eq({tag, "_last_key"}, last_key, lk);
`else
        if (lk == '0) $display("note: %s has no last-key reference", tag);
`endif
        finish_out();
    endtask

    logic [0:127] vk [3];
    logic [0:127] vp [3];
    logic [0:127] vc [3];
    logic         accept;

    initial begin
        int n;
        int acc, got, cyc, last_out;

        // Reset state
        step();
        check_eq("rst_in_ready", 128'(in_ready), 128'd0);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_ciphertext", ciphertext, 128'd0);
        rst_n = 1'b1;
        step();
        check_eq("in_ready_after_reset", 128'(in_ready), 128'd1);

        // FIPS-197 vectors
        run_vec("fips_c1", c_C1_KEY, c_C1_PT, c_C1_CT, c_C1_LK);
        run_vec("fips_b", c_B_KEY, c_B_PT, c_B_CT, c_B_LK);

        // Backpressure: result held for 20 cycles, stray in_valid ignored
        start(c_B_KEY, c_B_PT);
        wait_out(n);
        check_eq("bp_latency", 128'(n), 128'd10);
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i == 5);
            key       = c_C1_KEY;
            plaintext = c_C1_PT;
            step();
            check_eq("bp_out_valid_held", 128'(out_valid), 128'd1);
            check_eq("bp_ct_stable", ciphertext, c_B_CT);
            check_eq("bp_in_ready_low", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        finish_out();

        // Second request while rounds are running
        start(c_C1_KEY, c_C1_PT);
        for (int i = 0; i < 5; i++) step();
        key       = c_B_KEY;
        plaintext = c_B_PT;
        in_valid  = 1'b1;
        check_eq("busy_in_ready_low", 128'(in_ready), 128'd0);
        step();
        in_valid = 1'b0;
        wait_out(n);
        check_eq("busy_latency", 128'(n + 6), 128'd10);
        check_eq("busy_ct_unaffected", ciphertext, c_C1_CT);
        finish_out();

        // Reset in the middle of round 6
        start(c_C1_KEY, c_C1_PT);
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 128'(in_ready), 128'd0);
        check_eq("midrst_out_valid", 128'(out_valid), 128'd0);
        check_eq("midrst_busy", 128'(busy), 128'd0);
        check_eq("midrst_ciphertext", ciphertext, 128'd0);
`ifdef AES_ENC_LAST_KEY_EN
        check_eq("midrst_last_key", last_key, 128'd0);
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("midrst_no_out_valid", 128'(out_valid), 128'd0);
        end
        rst_n = 1'b1;
        step();
        check_eq("midrst_in_ready_back", 128'(in_ready), 128'd1);
        check_eq("midrst_no_spurious_valid", 128'(out_valid), 128'd0);
        run_vec("rerun_c1", c_C1_KEY, c_C1_PT, c_C1_CT, c_C1_LK);

        // Back-to-back with in_valid and out_ready held high
        vk[0] = c_C1_KEY; vp[0] = c_C1_PT; vc[0] = c_C1_CT;
        vk[1] = c_B_KEY;  vp[1] = c_B_PT;  vc[1] = c_B_CT;
        vk[2] = c_C1_KEY; vp[2] = c_C1_PT; vc[2] = c_C1_CT;
        acc = 0; got = 0; cyc = 0; last_out = -1;
        out_ready = 1'b1;
        key       = vk[0];
        plaintext = vp[0];
        in_valid  = 1'b1;
        while (got < 3 && cyc < 100) begin
            accept = in_valid && in_ready;
            step();
            cyc++;
            if (accept) begin
                acc++;
                if (acc < 3) begin
                    key       = vk[acc];
                    plaintext = vp[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check_eq("b2b_ct", ciphertext, vc[got]);
                if (got > 0) check_eq("b2b_spacing", 128'(cyc - last_out), 128'd12);
                last_out = cyc;
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("b2b_blocks_done", 128'(got), 128'd3);
        check_eq("b2b_blocks_accepted", 128'(acc), 128'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
